// File: rtl/aud_pkg.sv
// Shared audio-controller definitions: state encoding, SRAM address width and control bundle.
// Also imported by the recorder and playback DSP blocks.
package aud_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam logic [ADDR_W-1:0] ADDR_FULL = '1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REC        = 3'd1,
    REC_PAUSE  = 3'd2,
    PLAY       = 3'd3,
    PLAY_PAUSE = 3'd4
  } aud_state_e;

  // One-cycle control pulses sent to either the recorder or the DSP
  typedef struct packed {
    logic start;
    logic pause;
    logic stop;
  } aud_ctl_t;

endpackage

// File: rtl/aud_sram_mux.sv
// SRAM address / write-enable steering between recorder and playback DSP.
module aud_sram_mux
  import aud_pkg::*;
(
  input  aud_state_e        state,
  input  logic [ADDR_W-1:0] rec_addr,
  input  logic              rec_valid,
  input  logic [ADDR_W-1:0] dsp_addr,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we_n
);

  logic rec_owns;

  assign rec_owns  = (state == REC) || (state == REC_PAUSE);
  assign sram_addr = rec_owns ? rec_addr : dsp_addr;
  // Writes only while actively recording; a paused recorder never writes
  assign sram_we_n = !((state == REC) && rec_valid);

endmodule

// File: rtl/aud_ctrl.sv
// Record/playback controller: key-driven FSM issuing one-cycle recorder and DSP
// control pulses and remembering the length of the last recording.
module aud_ctrl
  import aud_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_mode_rec,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic              i_rec_valid,
  input  logic [ADDR_W-1:0] i_dsp_addr,
  input  logic              i_dsp_finished,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_dsp_start,
  output logic              o_dsp_pause,
  output logic              o_dsp_stop,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_we_n,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic [2:0]        o_state
);

  aud_state_e        state, state_nx;
  aud_ctl_t          rec_ctl, rec_ctl_nx;
  aud_ctl_t          dsp_ctl, dsp_ctl_nx;
  logic [ADDR_W-1:0] end_addr, end_addr_nx;
  logic              rec_full;

  assign rec_full = i_rec_valid && (i_rec_addr == ADDR_FULL);

  // State, pulse and end-address registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      rec_ctl  <= '0;
      dsp_ctl  <= '0;
      end_addr <= '0;
    end else begin
      state    <= state_nx;
      rec_ctl  <= rec_ctl_nx;
      dsp_ctl  <= dsp_ctl_nx;
      end_addr <= end_addr_nx;
    end
  end

  // Next state and pulses; stop > pause > start, losers dropped
  always_comb begin
    state_nx    = state;
    rec_ctl_nx  = '0;
    dsp_ctl_nx  = '0;
    end_addr_nx = end_addr;
    case (state)
      IDLE: begin
        if (i_start && !i_pause && !i_stop) begin
          if (i_mode_rec) begin
            state_nx         = REC;
            rec_ctl_nx.start = 1'b1;
            end_addr_nx      = '0;
          end else if (end_addr != '0) begin
            state_nx         = PLAY;
            dsp_ctl_nx.start = 1'b1;
          end
        end
      end
      REC: begin
        // A write to the last SRAM word ends the recording like a stop
        if (i_stop || rec_full) begin
          state_nx        = IDLE;
          rec_ctl_nx.stop = 1'b1;
          end_addr_nx     = i_rec_addr;
        end else if (i_pause) begin
          state_nx         = REC_PAUSE;
          rec_ctl_nx.pause = 1'b1;
        end
      end
      REC_PAUSE: begin
        if (i_stop) begin
          state_nx        = IDLE;
          rec_ctl_nx.stop = 1'b1;
          end_addr_nx     = i_rec_addr;
        end else if (i_start && !i_pause) begin
          state_nx         = REC;
          rec_ctl_nx.start = 1'b1;
        end
      end
      PLAY: begin
        if (i_stop) begin
          state_nx        = IDLE;
          dsp_ctl_nx.stop = 1'b1;
        end else if (i_dsp_finished) begin
          state_nx = IDLE;
        end else if (i_pause) begin
          state_nx         = PLAY_PAUSE;
          dsp_ctl_nx.pause = 1'b1;
        end
      end
      PLAY_PAUSE: begin
        if (i_stop) begin
          state_nx        = IDLE;
          dsp_ctl_nx.stop = 1'b1;
        end else if (i_start && !i_pause) begin
          state_nx         = PLAY;
          dsp_ctl_nx.start = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign o_rec_start = rec_ctl.start;
  assign o_rec_pause = rec_ctl.pause;
  assign o_rec_stop  = rec_ctl.stop;
  assign o_dsp_start = dsp_ctl.start;
  assign o_dsp_pause = dsp_ctl.pause;
  assign o_dsp_stop  = dsp_ctl.stop;
  assign o_end_addr  = end_addr;
  assign o_state     = state;

  aud_sram_mux u_sram_mux (
    .state     (state),
    .rec_addr  (i_rec_addr),
    .rec_valid (i_rec_valid),
    .dsp_addr  (i_dsp_addr),
    .sram_addr (o_sram_addr),
    .sram_we_n (o_sram_we_n)
  );

endmodule

// File: tb/tb_aud_ctrl.sv
// Directed bench for aud_ctrl: record, playback, pause/resume, empty playback,
// SRAM-full and reset-mid-record scenarios with hand-computed expectations.
module tb_aud_ctrl;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic        i_pause;
  logic        i_stop;
  logic        i_mode_rec;
  logic [19:0] i_rec_addr;
  logic        i_rec_valid;
  logic [19:0] i_dsp_addr;
  logic        i_dsp_finished;
  logic        o_rec_start, o_rec_pause, o_rec_stop;
  logic        o_dsp_start, o_dsp_pause, o_dsp_stop;
  logic [19:0] o_sram_addr;
  logic        o_sram_we_n;
  logic [19:0] o_end_addr;
  logic [2:0]  o_state;
  logic [5:0]  pulses;

  int n_cmp = 0;
  int n_err = 0;

  aud_ctrl dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_start        (i_start),
    .i_pause        (i_pause),
    .i_stop         (i_stop),
    .i_mode_rec     (i_mode_rec),
    .i_rec_addr     (i_rec_addr),
    .i_rec_valid    (i_rec_valid),
    .i_dsp_addr     (i_dsp_addr),
    .i_dsp_finished (i_dsp_finished),
    .o_rec_start    (o_rec_start),
    .o_rec_pause    (o_rec_pause),
    .o_rec_stop     (o_rec_stop),
    .o_dsp_start    (o_dsp_start),
    .o_dsp_pause    (o_dsp_pause),
    .o_dsp_stop     (o_dsp_stop),
    .o_sram_addr    (o_sram_addr),
    .o_sram_we_n    (o_sram_we_n),
    .o_end_addr     (o_end_addr),
    .o_state        (o_state)
  );

  // {rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop}
  assign pulses = {o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start, o_dsp_pause, o_dsp_stop};

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Present a one-cycle request then clear all requests
  task automatic req(input logic s, input logic p, input logic t);
    i_start = s;
    i_pause = p;
    i_stop  = t;
    step();
    i_start = 1'b0;
    i_pause = 1'b0;
    i_stop  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
    i_mode_rec = 1'b0; i_rec_addr = 20'h00000; i_rec_valid = 1'b0;
    i_dsp_addr = 20'h12345; i_dsp_finished = 1'b0;
    #12;
    chk("rst_state", 20'(o_state), 20'd0);
    chk("rst_end", o_end_addr, 20'h0);
    chk("rst_we_n", 20'(o_sram_we_n), 20'd1);
    chk("rst_sram_addr", o_sram_addr, 20'h12345);
    chk("rst_pulses", 20'(pulses), 20'(6'b000000));
    i_rst_n = 1'b1;
    step();

    // Empty playback: nothing recorded yet
    i_mode_rec = 1'b0;
    req(1'b1, 1'b0, 1'b0);
    chk("empty_pulses", 20'(pulses), 20'(6'b000000));
    chk("empty_state", 20'(o_state), 20'd0);

    // Record
    i_mode_rec = 1'b1;
    req(1'b1, 1'b0, 1'b0);
    chk("rec_start_pulse", 20'(pulses), 20'(6'b100000));
    chk("rec_state", 20'(o_state), 20'd1);
    i_rec_addr = 20'h00123; i_rec_valid = 1'b1; #1;
    chk("rec_we_n_valid", 20'(o_sram_we_n), 20'd0);
    chk("rec_sram_addr", o_sram_addr, 20'h00123);
    i_rec_valid = 1'b0; #1;
    chk("rec_we_n_idle", 20'(o_sram_we_n), 20'd1);
    i_mode_rec = 1'b0;
    step();
    chk("rec_start_one_cycle", 20'(pulses), 20'(6'b000000));
    chk("rec_mode_ignored", 20'(o_state), 20'd1);
    req(1'b0, 1'b1, 1'b0);
    chk("rec_pause_pulse", 20'(pulses), 20'(6'b010000));
    chk("rec_pause_state", 20'(o_state), 20'd2);
    i_rec_valid = 1'b1; #1;
    chk("rec_pause_we_n", 20'(o_sram_we_n), 20'd1);
    i_rec_valid = 1'b0;
    req(1'b1, 1'b0, 1'b0);
    chk("rec_resume_pulse", 20'(pulses), 20'(6'b100000));
    chk("rec_resume_state", 20'(o_state), 20'd1);
    i_rec_addr = 20'h00400;
    req(1'b0, 1'b0, 1'b1);
    chk("rec_stop_pulse", 20'(pulses), 20'(6'b001000));
    chk("rec_stop_end", o_end_addr, 20'h00400);
    chk("rec_stop_state", 20'(o_state), 20'd0);

    // Playback until the DSP reports completion
    i_mode_rec = 1'b0; i_dsp_addr = 20'h00055; i_rec_valid = 1'b1;
    req(1'b1, 1'b0, 1'b0);
    chk("play_start_pulse", 20'(pulses), 20'(6'b000100));
    chk("play_state", 20'(o_state), 20'd3);
    chk("play_sram_addr", o_sram_addr, 20'h00055);
    chk("play_we_n", 20'(o_sram_we_n), 20'd1);
    i_rec_valid = 1'b0;
    i_dsp_finished = 1'b1; step(); i_dsp_finished = 1'b0;
    chk("fin_state", 20'(o_state), 20'd0);
    chk("fin_no_stop", 20'(pulses), 20'(6'b000000));
    i_dsp_finished = 1'b1; step(); i_dsp_finished = 1'b0;
    chk("fin_idle_ignored", 20'(o_state), 20'd0);

    // Pause / resume, then simultaneous pause+stop
    req(1'b1, 1'b0, 1'b0);
    chk("pr_play_state", 20'(o_state), 20'd3);
    req(1'b0, 1'b1, 1'b0);
    chk("pr_pause_pulse", 20'(pulses), 20'(6'b000010));
    chk("pr_pause_state", 20'(o_state), 20'd4);
    req(1'b1, 1'b0, 1'b0);
    chk("pr_resume_pulse", 20'(pulses), 20'(6'b000100));
    chk("pr_resume_state", 20'(o_state), 20'd3);
    req(1'b0, 1'b1, 1'b1);
    chk("pr_stop_pulse", 20'(pulses), 20'(6'b000001));
    chk("pr_stop_state", 20'(o_state), 20'd0);
    chk("pr_end_kept", o_end_addr, 20'h00400);

    // SRAM full during record
    i_mode_rec = 1'b1;
    req(1'b1, 1'b0, 1'b0);
    chk("full_rec_state", 20'(o_state), 20'd1);
    chk("full_end_cleared", o_end_addr, 20'h0);
    i_rec_addr = 20'hFFFFF; i_rec_valid = 1'b1; #1;
    chk("full_we_n", 20'(o_sram_we_n), 20'd0);
    step();
    i_rec_valid = 1'b0;
    chk("full_stop_pulse", 20'(pulses), 20'(6'b001000));
    chk("full_end", o_end_addr, 20'hFFFFF);
    chk("full_state", 20'(o_state), 20'd0);

    // Reset mid-record discards the length and emits no stop
    i_rec_addr = 20'h00200;
    req(1'b1, 1'b0, 1'b0);
    chk("mid_rec_state", 20'(o_state), 20'd1);
    step();
    i_rec_valid = 1'b1; i_dsp_addr = 20'h0ABCD;
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 20'(o_state), 20'd0);
    chk("mid_rst_end", o_end_addr, 20'h0);
    chk("mid_rst_we_n", 20'(o_sram_we_n), 20'd1);
    chk("mid_rst_sram_addr", o_sram_addr, 20'h0ABCD);
    chk("mid_rst_pulses", 20'(pulses), 20'(6'b000000));
    step();
    chk("mid_rst_pulses_held", 20'(pulses), 20'(6'b000000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aud_ctrl.md
AUD_CTRL -- requirements
Module: aud_ctrl

Interface
REQ-001 The block SHALL have the following ports, one per line: name  direction  width  meaning.
  i_clk  in  1  system clock; all state changes on its rising edge.
  i_rst_n  in  1  reset, asynchronous assert, active-low.
  i_start  in  1  start/resume request, 1-cycle pulse (debounced key).
  i_pause  in  1  pause request, 1-cycle pulse.
  i_stop  in  1  stop request, 1-cycle pulse.
  i_mode_rec  in  1  1 = record mode, 0 = playback mode; sampled only in IDLE.
  i_rec_addr  in  20  SRAM write address from the recorder.
  i_rec_valid  in  1  recorder has a sample to write this cycle.
  i_dsp_addr  in  20  SRAM read address from the playback DSP.
  i_dsp_finished  in  1  DSP reached end address, 1-cycle pulse.
  o_rec_start / o_rec_pause / o_rec_stop  out  1 each  recorder controls, 1-cycle pulses.
  o_dsp_start / o_dsp_pause / o_dsp_stop  out  1 each  DSP controls, 1-cycle pulses.
  o_sram_addr  out  20  muxed SRAM address.
  o_sram_we_n  out  1  SRAM write enable, active-low.
  o_end_addr  out  20  last recorded address, fed to the DSP.
  o_state  out  3  current controller state, for LEDs/7-seg.

Function
REQ-002 The state machine SHALL have five states: IDLE=0, REC=1, REC_PAUSE=2, PLAY=3, PLAY_PAUSE=4.
REQ-003 Requests SHALL be prioritised stop > pause > start when they arrive in the same cycle; the losing requests are dropped.
REQ-004 In IDLE, i_start with i_mode_rec=1 SHALL go to REC, pulse o_rec_start for one cycle, and clear o_end_addr to 0.
REQ-005 In IDLE, i_start with i_mode_rec=0 and o_end_addr!=0 SHALL go to PLAY and pulse o_dsp_start; with o_end_addr==0 it SHALL be ignored.
REQ-006 REC + i_pause SHALL go to REC_PAUSE and pulse o_rec_pause; REC_PAUSE + i_start SHALL return to REC and pulse o_rec_start.
REQ-007 PLAY + i_pause SHALL go to PLAY_PAUSE and pulse o_dsp_pause; PLAY_PAUSE + i_start SHALL return to PLAY and pulse o_dsp_start.
REQ-008 i_stop in REC or REC_PAUSE SHALL go to IDLE, pulse o_rec_stop, and latch o_end_addr = i_rec_addr.
REQ-009 i_stop in PLAY or PLAY_PAUSE SHALL go to IDLE and pulse o_dsp_stop.
REQ-010 In PLAY, i_dsp_finished SHALL go to IDLE without pulsing o_dsp_stop; i_dsp_finished in any other state SHALL be ignored.
REQ-011 In REC, i_rec_valid with i_rec_addr==20'hFFFFF (SRAM full) SHALL still write, then go to IDLE, pulse o_rec_stop and latch o_end_addr=20'hFFFFF.
REQ-012 Every control pulse SHALL be registered, asserted exactly one cycle after the causing request, and never held for more than one cycle.
REQ-013 i_mode_rec SHALL have no effect outside IDLE.
REQ-014 o_sram_addr SHALL equal i_rec_addr in REC/REC_PAUSE and i_dsp_addr in all other states (combinational mux on registered state).
REQ-015 o_sram_we_n SHALL be 0 only in REC while i_rec_valid=1; it SHALL be 1 in every other state, including REC_PAUSE.
REQ-016 o_state SHALL present the encoded registered state.

Reset
REQ-017 On i_rst_n=0 the block SHALL asynchronously enter IDLE, with o_end_addr=0, all pulse outputs 0, o_sram_we_n=1 and o_sram_addr=i_dsp_addr.
REQ-018 A reset asserted mid-record or mid-playback SHALL discard the recording length (o_end_addr=0) and SHALL NOT emit stop pulses.

Structure
REQ-019 The state encoding and the 20-bit address width constant SHALL live in a shared package, aud_pkg, which the recorder and DSP also import.
REQ-020 The SRAM address/WE mux SHALL be a sub-module, aud_sram_mux; all remaining logic SHALL stay in aud_ctrl.

Verification
REQ-021 The bench SHALL cover the following directed scenarios.
  Record: reset; mode_rec=1; start -> o_rec_start pulses 1 cycle, o_state=1, we_n follows i_rec_valid; stop at i_rec_addr=0x00400 -> o_rec_stop, o_end_addr=0x00400, o_state=0.
  Playback: mode_rec=0; start -> o_dsp_start, o_state=3, o_sram_addr=i_dsp_addr, we_n=1; i_dsp_finished -> o_state=0, no o_dsp_stop.
  Pause/resume: pause in PLAY -> o_dsp_pause, o_state=4; start -> o_dsp_start, o_state=3; pause+stop in the same cycle -> only o_dsp_stop, o_state=0.
  Empty playback: after reset, mode_rec=0, start -> no pulse, o_state stays 0.
  SRAM full: REC with i_rec_valid at 0xFFFFF -> we_n=0 that cycle, then o_rec_stop, o_end_addr=0xFFFFF, IDLE.
  Reset mid-REC: assert i_rst_n=0 -> immediate IDLE, o_end_addr=0, we_n=1, no pulses.
